instr_fetch_unit: RTL and testbench



---
 rtl/core_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 38 +++
 rtl/fetch_buffer.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the RV32 front end.
// The fetch entry carries one instruction together with its PC and access-fault flag.
package core_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction memory request/response, decode handshake and control.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] instr_pc;
  logic            instr_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output instr_valid, instr_out, instr_pc, instr_fault,
    input  instr_ready,
    input  redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  instr_valid, instr_out, instr_pc, instr_fault,
    output instr_ready,
    output redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries with flush; push and pop may occur together.
// Storage is not reset, only the pointers and the count.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wr_entry,
  output fetch_entry_t               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch front end: sequential word fetch, in-order response buffering,
// decode handshake and redirect with discard of stale in-flight fetches.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);
  import core_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     inflight;
  logic            buf_empty;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_wr;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [XLEN-1:0] redirect_base;

  // Outstanding plus buffered never exceeds DEPTH, so a response always has a slot.
  assign inflight           = {1'b0, outstanding} + {1'b0, buf_count};
  assign bus.imem_req_valid = rst_n && !bus.halt && !bus.redirect_valid && (inflight < DEPTH_W);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_keep      = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign redirect_base = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign pop           = bus.instr_valid && bus.instr_ready;

  assign buf_wr = '{fault: bus.imem_rsp_err, pc: rsp_pc, instr: bus.imem_rsp_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        // No request can be accepted this cycle, so every older fetch still in flight is stale.
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
        end else if (bus.imem_rsp_valid) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rsp_keep),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .wr_entry (buf_wr),
    .head     (buf_head),
    .empty    (buf_empty),
    .count    (buf_count)
  );

  always_comb begin
    bus.instr_valid = !buf_empty;
    bus.instr_out   = NOP_INSTR;
    bus.instr_pc    = '0;
    bus.instr_fault = 1'b0;
    if (!buf_empty) begin
      bus.instr_out   = buf_head.instr;
      bus.instr_pc    = buf_head.pc;
      bus.instr_fault = buf_head.fault;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with random latency, randomized
// decode/redirect/halt traffic and a scoreboard of the architecturally expected PC stream.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  // stimulus knobs
  int rdy_pct = 100, dec_pct = 100, halt_pct = 0, redir_pct = 0, rst_pm = 0;
  int lat_min = 1, lat_max = 1;
  logic        rst_req = 1'b0, redir_req = 1'b0;
  logic [31:0] redir_tgt = '0;

  // monitor / model state
  logic [31:0] gen_pc = RESET_PC;
  logic [31:0] exp_req_addr = RESET_PC;
  int          acc_since_rst = 0;
  int          hs_cnt = 0;
  logic        in_rst = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return ((a >> 2) % 11) == 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    if ((r % 8) == 0) return 32'hFFFF_FFF0 | ($urandom % 16);
    return $urandom & 32'h0000_0FFF;
  endfunction

  task automatic tick();
    logic rst_now;
    @(negedge clk);
    rst_now = rst_req || (($urandom % 1000) < rst_pm);
    rst_n = !rst_now;
    bus.imem_req_ready = ($urandom % 100) < rdy_pct;
    bus.instr_ready    = ($urandom % 100) < dec_pct;
    bus.halt           = ($urandom % 100) < halt_pct;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = $urandom;
    if (!rst_now) begin
      if (redir_req) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = redir_tgt;
      end else if (($urandom % 100) < redir_pct) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = rand_target();
      end
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.imem_rsp_err   = 1'b0;
    if (rst_now) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_data(pend[0].addr);
      bus.imem_rsp_err   = mem_err(pend[0].addr);
      void'(pend.pop_front());
    end
    rst_req   = 1'b0;
    redir_req = 1'b0;
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_data(gen_pc), fault: mem_err(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // Monitor: samples 1 time unit after the negedge, before the next active edge.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("req_valid_in_reset", bus.imem_req_valid, 0);
      exp_q.delete();
      gen_pc        = RESET_PC;
      exp_req_addr  = RESET_PC;
      acc_since_rst = 0;
      in_rst        = 1'b1;
    end else begin
      if (in_rst) begin
        chk("valid_after_reset", bus.instr_valid, 0);
        chk("nop_after_reset", bus.instr_out, NOP);
      end
      in_rst = 1'b0;
      refill();
      if (bus.halt || bus.redirect_valid)
        chk("req_valid_blocked", bus.imem_req_valid, 0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        pend.push_back('{addr: bus.imem_req_addr,
                         due: cyc + lat_min + int'($urandom % (lat_max - lat_min + 1))});
        acc_since_rst++;
      end
      if (bus.instr_valid) begin
        chk("instr_pc", bus.instr_pc, exp_q[0].pc);
        chk("instr_out", bus.instr_out, exp_q[0].instr);
        chk("instr_fault", bus.instr_fault, exp_q[0].fault);
        if (bus.instr_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end else begin
        chk("idle_instr_out", bus.instr_out, NOP);
        chk("idle_instr_pc", bus.instr_pc, 0);
        chk("idle_instr_fault", bus.instr_fault, 0);
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        gen_pc       = {bus.redirect_pc[31:2], 2'b00};
        exp_req_addr = {bus.redirect_pc[31:2], 2'b00};
        refill();
      end
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_req = 1'b1;
      tick();
    end
  endtask

  initial begin
    int t;
    int hs0;
    logic found;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;

    // Streaming with a 1-cycle memory: first instruction two cycles after release.
    do_reset(3);
    t = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      #2;
      if (bus.instr_valid) begin
        found = 1'b1;
        t = i;
      end
    end
    chk("first_valid_cycle", t, 2);
    chk("first_valid_pc", bus.instr_pc, RESET_PC);
    hs0 = hs_cnt;
    for (int i = 0; i < 20; i++) tick();
    #2;
    chk("throughput_20", hs_cnt - hs0, 20);

    // Decode stalled: buffer fills to four entries and fetch stops.
    dec_pct = 0;
    do_reset(1);
    for (int i = 0; i < 12; i++) tick();
    #2;
    chk("full_req_valid", bus.imem_req_valid, 0);
    chk("full_accepts", acc_since_rst, 4);
    chk("full_head_pc", bus.instr_pc, 32'h0);
    dec_pct = 100;
    for (int i = 0; i < 10; i++) tick();

    // Redirect with fetches in flight on a 3-cycle memory.
    lat_min = 3;
    lat_max = 3;
    do_reset(1);
    for (int i = 0; i < 4; i++) tick();
    redir_req = 1'b1;
    redir_tgt = 32'h0000_0101;
    tick();
    for (int i = 0; i < 12; i++) tick();
    #2;
    chk("post_redirect_live", bus.instr_valid, 1);

    // Memory back-pressure at 0x20.
    lat_min = 1;
    lat_max = 1;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      #2;
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h1C) found = 1'b1;
    end
    chk("reach_0x1c", found, 1);
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      chk("held_addr", bus.imem_req_addr, 32'h20);
    end
    rdy_pct = 100;
    for (int i = 0; i < 10; i++) tick();

    // Reset mid-stream with entries buffered.
    dec_pct = 0;
    for (int i = 0; i < 3; i++) tick();
    do_reset(1);
    tick();
    #2;
    chk("midrst_valid", bus.instr_valid, 0);
    chk("midrst_nop", bus.instr_out, NOP);
    chk("midrst_req_addr", bus.imem_req_addr, RESET_PC);
    dec_pct = 100;
    for (int i = 0; i < 5; i++) tick();

    // Randomized traffic.
    rdy_pct   = 80;
    dec_pct   = 70;
    halt_pct  = 10;
    redir_pct = 5;
    rst_pm    = 2;
    lat_min   = 1;
    lat_max   = 4;
    hs0 = hs_cnt;
    for (int i = 0; i < 3000; i++) tick();
    #2;
    checks++;
    if (hs_cnt - hs0 < 300) begin
      errors++;
      $display("FAIL random_liveness: got %0d deliveries, expected at least 300", hs_cnt - hs0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
